// File: rtl/pipe_pkg.sv
// Shared types and defaults for the addpipe skid output stage.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CNT_W  = 16;

  // Buffer occupancy, encoded as {skid_valid, main_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/skid_slot.sv
// One buffer entry: data flop plus valid flop. Clear drops valid but keeps
// the data, load captures d_i and sets valid. Clear wins over load.
import pipe_pkg::*;

module skid_slot #(
  parameter int WIDTH = PIPE_DATA_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  // Data only moves on a load, so an idle bus never reaches the register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end else if (ld_i) begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer on a valid/ready stream. in_ready comes straight
// from a flop, so out_ready has no combinational path to in_ready.
// Optional feature macro STALL_CNT_EN adds a saturating downstream-stall
// counter (parameter CNT_W and port stall_cnt exist only with it).
import pipe_pkg::*;

module pipe_skid_reg #(
  parameter int WIDTH = PIPE_DATA_W
`ifdef STALL_CNT_EN
  , parameter int CNT_W = PIPE_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic [WIDTH-1:0] main_data, skid_data, main_din;
  logic             main_v, skid_v;
  logic             main_ld, main_clr, skid_ld, skid_clr;
  logic             in_xfer, out_xfer, skid_nxt;
  logic             in_ready_q, in_ready_d;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_v && out_ready;

  // Slot control: main holds the head word, skid catches the one word that
  // arrives while the head is stalled. flush overrides every transfer.
  always_comb begin
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_din = skid_v ? skid_data : in_data;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!main_v) begin
      main_ld  = in_xfer;
    end else if (out_xfer) begin
      // Head leaves: refill from skid first, else from the input, else empty.
      main_ld  = skid_v || in_xfer;
      main_clr = !skid_v && !in_xfer;
      skid_clr = skid_v;
    end else begin
      skid_ld  = in_xfer && !skid_v;
    end
    skid_nxt   = skid_clr ? 1'b0 : (skid_ld ? 1'b1 : skid_v);
    in_ready_d = !skid_nxt;
  end

  skid_slot #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .clr_n (clr_n),
    .clr_i (main_clr),
    .ld_i  (main_ld),
    .d_i   (main_din),
    .q_o   (main_data),
    .vld_o (main_v)
  );

  skid_slot #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .clr_n (clr_n),
    .clr_i (skid_clr),
    .ld_i  (skid_ld),
    .d_i   (in_data),
    .q_o   (skid_data),
    .vld_o (skid_v)
  );

  // Registered ready: mirrors the next-cycle emptiness of the skid slot.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) in_ready_q <= 1'b1;
    else        in_ready_q <= in_ready_d;
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data;
  assign out_valid = main_v;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Count cycles the head is presented but refused; saturate at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (flush)
      stall_d = '0;
    else if (main_v && !out_ready && stall_q != {CNT_W{1'b1}})
      stall_d = stall_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

`ifndef SYNTHESIS
  state_e state_dbg;
  assign state_dbg = state_e'({skid_v, main_v});

  // Skid must never hold a word while main is empty.
  always_ff @(posedge clk) begin
    if (clr_n) assert (state_dbg inside {EMPTY, ONE, FULL});
  end
`endif

endmodule
